// File: rtl/channel_endpoint_pkg.sv
// Shared channel message definitions: default widths, broadcast destination and field helpers.
package channel_pkg;

    localparam int unsigned DEFAULT_CHANNEL_WIDTH = 64;
    localparam int unsigned DEFAULT_DEST_WIDTH    = 8;
    localparam int unsigned DEFAULT_PAYLOAD_WIDTH = DEFAULT_CHANNEL_WIDTH - DEFAULT_DEST_WIDTH;

    localparam logic [DEFAULT_DEST_WIDTH-1:0] BROADCAST_DEST = '1;

    typedef struct packed {
        logic [DEFAULT_DEST_WIDTH-1:0]    dest;
        logic [DEFAULT_PAYLOAD_WIDTH-1:0] payload;
    } msg_t;

    function automatic logic [DEFAULT_DEST_WIDTH-1:0] msg_dest(input msg_t msg);
        return msg.dest;
    endfunction

    function automatic logic [DEFAULT_PAYLOAD_WIDTH-1:0] msg_payload(input msg_t msg);
        return msg.payload;
    endfunction

    function automatic msg_t make_msg(input logic [DEFAULT_DEST_WIDTH-1:0]    dest,
                                      input logic [DEFAULT_PAYLOAD_WIDTH-1:0] payload);
        msg_t m;
        m.dest    = dest;
        m.payload = payload;
        return m;
    endfunction

endpackage

// File: rtl/channel_endpoint_if.sv
// Endpoint signal bundle: local tx/rx handshakes, router-facing handshakes and misroute status.
interface channel_endpoint_if
    import channel_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH,
    parameter int unsigned DEST_WIDTH    = DEFAULT_DEST_WIDTH,
    parameter int unsigned RX_DEPTH      = 4
);
    localparam int unsigned PAYLOAD_WIDTH = CHANNEL_WIDTH - DEST_WIDTH;
    localparam int unsigned COUNT_WIDTH   = $clog2(RX_DEPTH) + 1;

    logic                     tx_valid;
    logic                     tx_ready;
    logic [DEST_WIDTH-1:0]    tx_dest;
    logic [PAYLOAD_WIDTH-1:0] tx_payload;

    logic [CHANNEL_WIDTH-1:0] net_tx_data;
    logic                     net_tx_valid;
    logic                     net_tx_ready;
    logic [CHANNEL_WIDTH-1:0] net_rx_data;
    logic                     net_rx_valid;
    logic                     net_rx_ready;

    logic                     rx_valid;
    logic                     rx_ready;
    logic [PAYLOAD_WIDTH-1:0] rx_payload;
    logic                     rx_broadcast;
    logic [COUNT_WIDTH-1:0]   rx_count;

    logic                     misroute_err;
    logic [7:0]               misroute_cnt;

    // Endpoint side
    modport slave (
        input  tx_valid, tx_dest, tx_payload,
        output tx_ready,
        output net_tx_data, net_tx_valid,
        input  net_tx_ready,
        input  net_rx_data, net_rx_valid,
        output net_rx_ready,
        output rx_valid, rx_payload, rx_broadcast, rx_count,
        input  rx_ready,
        output misroute_err, misroute_cnt
    );

    // Environment side: local producer/consumer and router
    modport master (
        output tx_valid, tx_dest, tx_payload,
        input  tx_ready,
        input  net_tx_data, net_tx_valid,
        output net_tx_ready,
        output net_rx_data, net_rx_valid,
        input  net_rx_ready,
        input  rx_valid, rx_payload, rx_broadcast, rx_count,
        output rx_ready,
        input  misroute_err, misroute_cnt
    );

endinterface

// File: rtl/channel_endpoint_fifo.sv
// endpoint_fifo: synchronous first-word-fall-through FIFO, DEPTH a power of 2.
module endpoint_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH because DEPTH is a power of 2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/channel_endpoint.sv
// channel_endpoint: egress pipeline register into the router and FWFT ingress buffer toward the consumer.
// Optional misroute filtering/counting enabled by CHANNEL_ENDPOINT_MISROUTE_CHECK_EN.
module channel_endpoint
    import channel_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH,
    parameter int unsigned DEST_WIDTH    = DEFAULT_DEST_WIDTH,
    parameter int unsigned MY_ID         = 0,
    parameter int unsigned RX_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    channel_endpoint_if.slave  ep
);
    localparam int unsigned PAYLOAD_WIDTH = CHANNEL_WIDTH - DEST_WIDTH;
    localparam int unsigned COUNT_WIDTH   = $clog2(RX_DEPTH) + 1;
    localparam logic [DEST_WIDTH-1:0] BCAST   = '1;
    localparam logic [DEST_WIDTH-1:0] MY_DEST = DEST_WIDTH'(MY_ID);

    // Egress: one register stage, refillable in the same cycle it drains
    assign ep.tx_ready = ~ep.net_tx_valid | ep.net_tx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ep.net_tx_valid <= 1'b0;
            ep.net_tx_data  <= '0;
        end else if (ep.tx_valid && ep.tx_ready) begin
            ep.net_tx_valid <= 1'b1;
            ep.net_tx_data  <= {ep.tx_dest, ep.tx_payload};
        end else if (ep.net_tx_ready) begin
            ep.net_tx_valid <= 1'b0;
        end
    end

    // Ingress: ready comes from registered occupancy only, never from net_rx_valid
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic [CHANNEL_WIDTH-1:0] fifo_head;
    logic                     rx_accept;
    logic [DEST_WIDTH-1:0]    rx_dest;
    logic                     misrouted;

    assign ep.net_rx_ready = ~fifo_full;
    assign rx_accept       = ep.net_rx_valid & ~fifo_full;
    assign rx_dest         = ep.net_rx_data[CHANNEL_WIDTH-1 -: DEST_WIDTH];
    assign misrouted       = (rx_dest != MY_DEST) && (rx_dest != BCAST);

`ifdef CHANNEL_ENDPOINT_MISROUTE_CHECK_EN
    logic       mis_err_q;
    logic [7:0] mis_cnt_q;

    assign fifo_push = rx_accept & ~misrouted;

    // Misrouted messages are drained from the router but dropped here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mis_err_q <= 1'b0;
            mis_cnt_q <= 8'h00;
        end else if (rx_accept && misrouted) begin
            mis_err_q <= 1'b1;
            if (mis_cnt_q != 8'hFF) mis_cnt_q <= mis_cnt_q + 8'd1;
        end
    end

    assign ep.misroute_err = mis_err_q;
    assign ep.misroute_cnt = mis_cnt_q;
`else
    logic unused_misrouted;

    assign fifo_push        = rx_accept;
    assign unused_misrouted = misrouted;
    assign ep.misroute_err  = 1'b0;
    assign ep.misroute_cnt  = 8'h00;
`endif

    assign fifo_pop = ~fifo_empty & ep.rx_ready;

    endpoint_fifo #(
        .WIDTH (CHANNEL_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wdata   (ep.net_rx_data),
        .pop     (fifo_pop),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (ep.rx_count)
    );

    // Head fields are forced to zero while the buffer is empty
    assign ep.rx_valid     = ~fifo_empty;
    assign ep.rx_payload   = fifo_empty ? '0 : fifo_head[PAYLOAD_WIDTH-1:0];
    assign ep.rx_broadcast = ~fifo_empty & (&fifo_head[CHANNEL_WIDTH-1 -: DEST_WIDTH]);

    if (COUNT_WIDTH < 2) begin : g_bad_depth
        $error("RX_DEPTH must be a power of 2 and at least 2");
    end

endmodule

// File: tb/tb_channel_endpoint.sv
// Randomized + directed bench for channel_endpoint against a queue-based behavioural model.
module tb_channel_endpoint;
    import channel_pkg::*;

    localparam int unsigned CW    = 64;
    localparam int unsigned DW    = 8;
    localparam int unsigned PW    = CW - DW;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MY_ID = 0;

    logic clk;
    logic reset_n;

    channel_endpoint_if #(.CHANNEL_WIDTH(CW), .DEST_WIDTH(DW), .RX_DEPTH(DEPTH)) bus ();

    channel_endpoint #(
        .CHANNEL_WIDTH (CW),
        .DEST_WIDTH    (DW),
        .MY_ID         (MY_ID),
        .RX_DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ep      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: the one egress slot, the ingress queue, misroute total
    logic          m_nv;
    logic [CW-1:0] m_nd;
    logic [CW-1:0] rxq[$];
    int            m_mis_n;
    int            dut_pops;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit keep_msg(input logic [DW-1:0] d);
`ifdef CHANNEL_ENDPOINT_MISROUTE_CHECK_EN
        return (d == DW'(MY_ID)) || (d == BROADCAST_DEST);
`else
        return (d == d);
`endif
    endfunction

    function automatic logic [7:0] exp_mis_cnt();
`ifdef CHANNEL_ENDPOINT_MISROUTE_CHECK_EN
        return (m_mis_n > 255) ? 8'hFF : 8'(m_mis_n);
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_reset();
        m_nv    = 1'b0;
        m_nd    = '0;
        rxq.delete();
        m_mis_n = 0;
    endtask

    task automatic check_regs();
        logic [CW-1:0] head;
        head = (rxq.size() > 0) ? rxq[0] : '0;
        check("net_tx_valid", 64'(bus.net_tx_valid), 64'(m_nv));
        check("net_tx_data",  bus.net_tx_data, m_nd);
        check("rx_valid",     64'(bus.rx_valid), 64'(rxq.size() > 0));
        check("rx_payload",   64'(bus.rx_payload), 64'(head[PW-1:0]));
        check("rx_broadcast", 64'(bus.rx_broadcast), 64'((rxq.size() > 0) && (head[CW-1 -: DW] == BROADCAST_DEST)));
        check("rx_count",     64'(bus.rx_count), 64'(rxq.size()));
        check("misroute_err", 64'(bus.misroute_err), 64'(exp_mis_cnt() != 8'h00));
        check("misroute_cnt", 64'(bus.misroute_cnt), 64'(exp_mis_cnt()));
    endtask

    // One clock: inputs already set at the falling edge
    task automatic step();
        logic rdy_exp, nrr_exp, acc, wr, pop;
        #1;
        rdy_exp = !m_nv || bus.net_tx_ready;
        nrr_exp = (rxq.size() < DEPTH);
        check("tx_ready",     64'(bus.tx_ready), 64'(rdy_exp));
        check("net_rx_ready", 64'(bus.net_rx_ready), 64'(nrr_exp));
        if (bus.rx_valid && bus.rx_ready) dut_pops++;
        acc = bus.tx_valid && rdy_exp;
        wr  = bus.net_rx_valid && nrr_exp;
        pop = (rxq.size() > 0) && bus.rx_ready;
        if (acc) begin
            m_nv = 1'b1;
            m_nd = {bus.tx_dest, bus.tx_payload};
        end else if (bus.net_tx_ready) begin
            m_nv = 1'b0;
        end
        if (pop) void'(rxq.pop_front());
        if (wr) begin
            if (keep_msg(bus.net_rx_data[CW-1 -: DW])) rxq.push_back(bus.net_rx_data);
            else m_mis_n++;
        end
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.tx_valid     = 1'b0;
        bus.tx_dest      = '0;
        bus.tx_payload   = '0;
        bus.net_tx_ready = 1'b0;
        bus.net_rx_valid = 1'b0;
        bus.net_rx_data  = '0;
        bus.rx_ready     = 1'b0;
    endtask

    function automatic logic [PW-1:0] rand_payload();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_dest();
        case ($urandom_range(0, 3))
            0:       return DW'(MY_ID);
            1:       return BROADCAST_DEST;
            2:       return 8'h03;
            default: return DW'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        idle_inputs();
        reset_n  = 1'b0;
        dut_pops = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_net_tx_valid", 64'(bus.net_tx_valid), 64'h0);
        check("rst_net_tx_data",  bus.net_tx_data, 64'h0);
        check("rst_rx_count",     64'(bus.rx_count), 64'h0);

        // Egress held under backpressure, then one transfer
        bus.tx_valid = 1'b1; bus.tx_dest = 8'h01; bus.tx_payload = 56'hABC;
        step();
        check("t2_data", bus.net_tx_data, 64'h0100_0000_0000_0ABC);
        bus.tx_payload = 56'h123;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_tx_ready_low", 64'(bus.tx_ready), 64'h0);
            check("t2_data_held", bus.net_tx_data, 64'h0100_0000_0000_0ABC);
        end
        bus.tx_valid = 1'b0; bus.net_tx_ready = 1'b1;
        step();
        check("t2_valid_drop", 64'(bus.net_tx_valid), 64'h0);

        // Back-to-back egress at full rate
        for (int i = 0; i < 6; i++) begin
            bus.tx_valid = 1'b1; bus.tx_dest = 8'(i + 2); bus.tx_payload = 56'(i * 17 + 5);
            step();
            check("t3_continuous", 64'(bus.net_tx_valid), 64'h1);
        end
        check("t3_last", bus.net_tx_data, 64'h0700_0000_0000_005A);
        idle_inputs();
        bus.net_tx_ready = 1'b1;
        step();

        // Broadcast and local-dest flagging
        bus.net_rx_valid = 1'b1;
        bus.net_rx_data  = make_msg(BROADCAST_DEST, 56'hDEAD_BEEF);
        step();
        check("t5_bcast", 64'(bus.rx_broadcast), 64'h1);
        check("t5_bcast_payload", 64'(bus.rx_payload), 64'hDEAD_BEEF);
        bus.net_rx_data = make_msg(8'(MY_ID), 56'h55);
        bus.rx_ready    = 1'b1;
        step();
        check("t5_local", 64'(bus.rx_broadcast), 64'h0);
        check("t5_local_payload", 64'(bus.rx_payload), 64'h55);
        bus.net_rx_valid = 1'b0;
        step();

        // Fill to full, 5th held by router, pop frees one slot
        bus.rx_ready = 1'b0; bus.net_rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.net_rx_data = make_msg(8'(MY_ID), 56'(i + 1));
            step();
        end
        check("t4_full_ready", 64'(bus.net_rx_ready), 64'h0);
        check("t4_full_count", 64'(bus.rx_count), 64'h4);
        check("t4_head", 64'(bus.rx_payload), 64'h1);
        bus.net_rx_data = make_msg(8'(MY_ID), 56'h5);
        step();
        bus.rx_ready = 1'b1;
        step();
        check("t4_after_pop_ready", 64'(bus.net_rx_ready), 64'h1);
        check("t4_after_pop_count", 64'(bus.rx_count), 64'h3);
        check("t4_after_pop_head", 64'(bus.rx_payload), 64'h2);
        bus.rx_ready = 1'b0;
        step();
        bus.net_rx_valid = 1'b0; bus.rx_ready = 1'b1;
        repeat (5) step();

        // Misrouted stream
        dut_pops = 0;
        bus.net_rx_valid = 1'b1; bus.rx_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.net_rx_data = make_msg(8'h03, 56'(i));
            step();
        end
        bus.net_rx_valid = 1'b0;
        repeat (3) step();
`ifdef CHANNEL_ENDPOINT_MISROUTE_CHECK_EN
        check("t6_mis_cnt", 64'(bus.misroute_cnt), 64'hFF);
        check("t6_mis_err", 64'(bus.misroute_err), 64'h1);
        check("t6_none_queued", 64'(dut_pops), 64'd0);
`else
        check("t6_mis_cnt", 64'(bus.misroute_cnt), 64'h0);
        check("t6_mis_err", 64'(bus.misroute_err), 64'h0);
        check("t6_all_queued", 64'(dut_pops), 64'd300);
`endif

        // Randomized traffic with phases of heavy and light consumer pressure
        for (int i = 0; i < 2000; i++) begin
            bus.tx_valid     = 1'($urandom_range(0, 1));
            bus.tx_dest      = rand_dest();
            bus.tx_payload   = rand_payload();
            bus.net_tx_ready = ($urandom_range(0, 3) != 0);
            bus.net_rx_valid = 1'($urandom_range(0, 1));
            bus.net_rx_data  = {rand_dest(), rand_payload()};
            bus.rx_ready     = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset mid-burst with three queued entries and egress valid
        idle_inputs();
        bus.rx_ready = 1'b1; bus.net_tx_ready = 1'b1;
        repeat (6) step();
        bus.rx_ready = 1'b0; bus.net_tx_ready = 1'b0; bus.net_rx_valid = 1'b1;
        bus.tx_valid = 1'b1; bus.tx_dest = 8'h02; bus.tx_payload = 56'h77;
        for (int i = 0; i < 3; i++) begin
            bus.net_rx_data = make_msg(8'(MY_ID), 56'(i + 10));
            step();
        end
        check("t1_pre_count", 64'(bus.rx_count), 64'h3);
        check("t1_pre_valid", 64'(bus.net_tx_valid), 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t1_net_tx_valid", 64'(bus.net_tx_valid), 64'h0);
        check("t1_net_tx_data",  bus.net_tx_data, 64'h0);
        check("t1_rx_valid",     64'(bus.rx_valid), 64'h0);
        check("t1_rx_count",     64'(bus.rx_count), 64'h0);
        check("t1_rx_payload",   64'(bus.rx_payload), 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
        step();
        check("t1_rx_ready_after", 64'(bus.net_rx_ready), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
